// File: rtl/rgb565_grayscale4_ci.sv
// -----------------------------------------------------------------------------
// rgb565_grayscale4_ci
//
// Multi-cycle custom instruction that converts four RGB565 pixels into four
// 8-bit grayscale values per issue, packed into one 32-bit result.
//
//   gray = clamp255( (R8*RC + G8*GC + B8*BC) >> 8 )
//
// R8/G8/B8 are the 5/6/5-bit channels widened to 8 bits by replicating their
// top bits, so full-scale channels map to 8'hFF. Truncation only, no rounding.
//
// Timing: start accepted in cycle N -> products registered (MUL, cycle N+1)
//         -> sums clamped and packed, done=1 in cycle N+2 (SUM) -> IDLE.
// A start that arrives while MUL or SUM is in progress is dropped; the CPU
// is expected to stall until done.
//
// Parameters:
//   customInstructionId  instruction ID this block answers to
//   RED_COEF             red weight   (1/256 units)
//   GREEN_COEF           green weight (1/256 units)
//   BLUE_COEF            blue weight  (1/256 units)
//
// Ports:
//   clock   in   1   rising-edge clock
//   reset   in   1   asynchronous active-high reset, aborts any operation
//   start   in   1   one-cycle instruction strobe
//   iseId   in   8   ID of the instruction being issued
//   valueA  in  32   pixel 0 in [15:0], pixel 1 in [31:16]
//   valueB  in  32   pixel 2 in [15:0], pixel 3 in [31:16]
//   done    out  1   one-cycle completion pulse
//   result  out 32   gray(p0)[7:0] .. gray(p3)[31:24]; zero unless done=1
//
// Optional feature, macro GRAYSCALE_COEF_PROG_EN:
//   When defined, ID customInstructionId+1 is a coefficient write:
//   red <= valueA[7:0], green <= valueA[15:8], blue <= valueA[23:16],
//   done pulses one cycle later with result=0. Coefficients reset to the
//   parameter values. When undefined, the weights are fixed constants and
//   ID customInstructionId+1 is ignored.
// -----------------------------------------------------------------------------
module rgb565_grayscale4_ci #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter logic [7:0] RED_COEF            = 8'd54,
    parameter logic [7:0] GREEN_COEF          = 8'd183,
    parameter logic [7:0] BLUE_COEF           = 8'd19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int NPIX  = 4;
    localparam int NPROD = 3 * NPIX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions: channel widening and saturation
    // ------------------------------------------------------------------
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

    // Scales an 18-bit weighted sum down by 256 and saturates to 8 bits.
    // Three 8x8 products can reach 3*255*255, i.e. a 10-bit quotient.
    function automatic logic [7:0] sat_u8(input logic [17:0] sum);
        logic [9:0] scaled;
        scaled = 10'(sum >> 8);
        return (scaled > 10'd255) ? 8'hFF : scaled[7:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [15:0] prod_p1_q [NPROD];

    logic [7:0]  coef_r;
    logic [7:0]  coef_g;
    logic [7:0]  coef_b;

`ifdef GRAYSCALE_COEF_PROG_EN
    localparam logic [7:0] COEF_WR_ID = customInstructionId + 8'd1;

    logic [7:0]  coef_r_q;
    logic [7:0]  coef_g_q;
    logic [7:0]  coef_b_q;
    logic        accept_coef;

    assign coef_r      = coef_r_q;
    assign coef_g      = coef_g_q;
    assign coef_b      = coef_b_q;
    assign accept_coef = start && (iseId == COEF_WR_ID);
`else
    assign coef_r = RED_COEF;
    assign coef_g = GREEN_COEF;
    assign coef_b = BLUE_COEF;
`endif

    logic        accept_conv;
    assign accept_conv = start && (iseId == customInstructionId);

    // ------------------------------------------------------------------
    // Stage 0 -> 1: widen channels and form the twelve weighted products
    // ------------------------------------------------------------------
    logic [15:0] pix      [NPIX];
    logic [15:0] prod_p1_d [NPROD];

    always_comb begin
        pix[0] = valueA[15:0];
        pix[1] = valueA[31:16];
        pix[2] = valueB[15:0];
        pix[3] = valueB[31:16];
        for (int i = 0; i < NPIX; i++) begin
            prod_p1_d[3*i]     = {8'd0, expand5(pix[i][15:11])} * {8'd0, coef_r};
            prod_p1_d[3*i + 1] = {8'd0, expand6(pix[i][10:5])}  * {8'd0, coef_g};
            prod_p1_d[3*i + 2] = {8'd0, expand5(pix[i][4:0])}   * {8'd0, coef_b};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2: per-pixel sum, scale, clamp and pack
    // ------------------------------------------------------------------
    logic [17:0] sum_p2   [NPIX];
    logic [31:0] packed_p2_d;

    always_comb begin
        packed_p2_d = 32'd0;
        for (int i = 0; i < NPIX; i++) begin
            sum_p2[i] = {2'b00, prod_p1_q[3*i]}
                      + {2'b00, prod_p1_q[3*i + 1]}
                      + {2'b00, prod_p1_q[3*i + 2]};
            packed_p2_d[8*i +: 8] = sat_u8(sum_p2[i]);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            for (int k = 0; k < NPROD; k++) begin
                prod_p1_q[k] <= 16'd0;
            end
`ifdef GRAYSCALE_COEF_PROG_EN
            coef_r_q <= RED_COEF;
            coef_g_q <= GREEN_COEF;
            coef_b_q <= BLUE_COEF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q   <= 1'b0;
                    result_q <= 32'd0;
                    if (accept_conv) begin
                        for (int k = 0; k < NPROD; k++) begin
                            prod_p1_q[k] <= prod_p1_d[k];
                        end
                        state_q <= MUL;
                    end
`ifdef GRAYSCALE_COEF_PROG_EN
                    else if (accept_coef) begin
                        // Coefficient write completes in one cycle; SUM is
                        // reused only to hold the done pulse for a cycle.
                        coef_r_q <= valueA[7:0];
                        coef_g_q <= valueA[15:8];
                        coef_b_q <= valueA[23:16];
                        done_q   <= 1'b1;
                        state_q  <= SUM;
                    end
`endif
                end
                MUL: begin
                    result_q <= packed_p2_d;
                    done_q   <= 1'b1;
                    state_q  <= SUM;
                end
                SUM: begin
                    // Any start seen here is dropped; the CPU is stalled.
                    done_q   <= 1'b0;
                    result_q <= 32'd0;
                    state_q  <= IDLE;
                end
                default: begin
                    done_q   <= 1'b0;
                    result_q <= 32'd0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
